// File: rtl/csr_uart_rx_fifo_pkg.sv
// Shared definitions for the CSR-mapped UART receiver: receiver FSM state
// encoding, the default CSR address and the layout of the status word.
package csr_uart_rx_fifo_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_START = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_BREAK = 3'd4;

  localparam logic [11:0] RX_CSR_ADDR = 12'hBC3;

  // Returned when the FIFO is empty; cannot collide with a real status word
  // because bits [31:18] of a status word are always zero.
  localparam logic [31:0] RDATA_EMPTY = 32'hFFFF_FFFF;

  // Status word layout: [17] frame_err, [16] overrun, [15:8] count, [7:0] byte.
  typedef struct packed {
    logic [13:0] rsvd;
    logic        frame_err;
    logic        overrun;
    logic [7:0]  count;
    logic [7:0]  data;
  } rx_status_t;

endpackage

// File: rtl/csr_uart_rx_fifo_sync.sv
// Synchronous FIFO with registered storage, reusable by RX and TX paths.
// Ports: clk, rst (async, active-high), push/din write side, pop/dout read
// side (dout shows the head combinationally), flush clears pointers and
// count, count/full/empty status, nonempty is a registered copy of
// (count != 0) updated on the same edge as count.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  nonempty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  wr_en_c;
  logic                  rd_en_c;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push while full is accepted only if a pop frees the head slot this edge.
  assign wr_en_c = push && (!full || pop);
  assign rd_en_c = pop && !empty;

  always_comb begin
    count_d = count;
    if (flush) count_d = '0;
    else       count_d = count + CW'(wr_en_c) - CW'(rd_en_c);
  end

  // Pointers, count and registered non-empty flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      nonempty <= 1'b0;
    end else begin
      count    <= count_d;
      nonempty <= (count_d != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en_c) wr_ptr <= wr_ptr + PW'(1);
        if (rd_en_c) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/csr_uart_rx_fifo.sv
// CSR-mapped 8N1 UART receiver with a receive FIFO.
// Ports: clk, rst (async, active-high); rx serial input (idle high, async);
// read/write/wdata/addr CSR request; rdata/valid same-cycle CSR response
// (zero when not addressed, so it can be ORed with other CSR blocks);
// irq_rx registered level interrupt, high while the FIFO holds data.
module csr_uart_rx_fifo
  import csr_uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLOCK_RATE      = 200_000_000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter logic [11:0] CSR_ADDR        = RX_CSR_ADDR,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        irq_rx
);

  localparam int unsigned DIVISOR = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CNT_W   = $clog2(DIVISOR);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);

  logic [1:0]         sync_q;
  logic               rxs;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_d;
  logic [2:0]         bit_idx;
  logic [2:0]         bit_idx_d;
  logic [7:0]         shift;
  logic [7:0]         shift_d;
  logic               push_c;
  logic               frame_set_c;

  logic                     overrun;
  logic                     frame_err;
  logic [7:0]               fifo_dout;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_nonempty;

  logic       hit_c;
  logic       rd_hit_c;
  logic       wr_hit_c;
  logic       pop_c;
  logic       clr_err_c;
  logic       flush_c;
  logic       ovr_set_c;
  rx_status_t status_c;
  logic       unused_wdata_c;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rxs = sync_q[1];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Receiver datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
    end
  end

  // Next-state and bit-sampling logic; samples land mid-bit because the
  // start bit is timed with a half-period load.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shift_d     = shift;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
    if (cnt != '0) cnt_d = cnt - CNT_W'(1);
    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_d   = HALF_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d     = FULL_LOAD;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          shift_d = {rxs, shift[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx == 3'd7) state_d   = ST_STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            push_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set_c = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_c),
    .pop      (pop_c),
    .flush    (flush_c),
    .din      (shift),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .nonempty (fifo_nonempty)
  );

  // CSR decode; combinational so the pipeline gets its answer this cycle.
  assign hit_c     = (addr == CSR_ADDR);
  assign rd_hit_c  = read && hit_c;
  assign wr_hit_c  = write && hit_c;
  assign valid     = hit_c && (read || write);
  assign pop_c     = rd_hit_c && !fifo_empty;
  assign clr_err_c = wr_hit_c && wdata[0];
  assign flush_c   = wr_hit_c && wdata[1];
  assign ovr_set_c = push_c && fifo_full && !pop_c;
  assign unused_wdata_c = ^wdata[31:2];

  always_comb begin
    status_c           = '0;
    status_c.frame_err = frame_err;
    status_c.overrun   = overrun;
    status_c.count     = 8'(fifo_count);
    status_c.data      = fifo_dout;
  end

  always_comb begin
    rdata = '0;
    if (rd_hit_c) rdata = fifo_empty ? RDATA_EMPTY : status_c;
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_set_c)      overrun   <= 1'b1;
      else if (clr_err_c) overrun   <= 1'b0;
      if (frame_set_c)    frame_err <= 1'b1;
      else if (clr_err_c) frame_err <= 1'b0;
    end
  end

  assign irq_rx = fifo_nonempty;

endmodule
